// File: rtl/fp_addsub_pkg.sv
// Shared types and field positions for the floating-point add/sub issue path.
package fp_addsub_pkg;

  // IEEE 754 single-precision layout
  localparam int FP_WIDTH = 32;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;

  // Operation selector carried with every issued operation
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Requester identity travelling down the tag pipeline
  typedef logic req_id_t;

  localparam req_id_t REQ_ID0 = 1'b0;
  localparam req_id_t REQ_ID1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grants, registered priority.
module rr_arbiter2
  import fp_addsub_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  req_id_t prio;

  // A requester wins when it holds priority or the other side is idle;
  // prio is a single bit, so the two grants can never both be high.
  assign gnt0 = en & req0 & ((prio == REQ_ID0) | ~req1);
  assign gnt1 = en & req1 & ((prio == REQ_ID1) | ~req0);

  // Priority flips to the loser after each grant and holds otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio <= REQ_ID0;
    end else if (gnt0) begin
      prio <= REQ_ID1;
    end else if (gnt1) begin
      prio <= REQ_ID0;
    end
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one external fixed-latency FP add/sub datapath between two
// requesters. Each grant is registered into an issue stage, a LAT-deep tag
// pipeline remembers who issued it, and the datapath result is registered
// back to the owning requester as a one-cycle pulse. LAT must be 1..8.
module fp_addsub_arbiter
  import fp_addsub_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             dp_valid,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_op,
  input  logic [WIDTH-1:0] dp_res,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_ovf,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_ovf,
  output logic             busy
);

  // Exponent field all ones: infinity or NaN came back from the datapath
  function automatic logic exp_sat(input logic [WIDTH-1:0] x);
    return (x[EXP_MSB:EXP_LSB] == 8'hFF);
  endfunction

  logic gnt0;
  logic gnt1;
  logic gnt_any;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req0  (req0_valid),
    .req1  (req1_valid),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign gnt_any    = gnt0 | gnt1;

  // ---- stage p0: issue register feeding the datapath ----
  logic             vld_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  op_e              op_p0;
  req_id_t          id_p0;

  // Capture the granted operation; operands hold when nothing is granted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
      op_p0  <= OP_ADD;
      id_p0  <= REQ_ID0;
    end else begin
      vld_p0 <= gnt_any;
      if (gnt_any) begin
        a_p0  <= gnt1 ? req1_a : req0_a;
        b_p0  <= gnt1 ? req1_b : req0_b;
        op_p0 <= op_e'(gnt1 ? req1_op : req0_op);
        id_p0 <= gnt1 ? REQ_ID1 : REQ_ID0;
      end
    end
  end

  assign dp_valid = vld_p0;
  assign dp_a     = a_p0;
  assign dp_b     = b_p0;
  assign dp_op    = op_p0;

  // ---- stage p1: tag pipeline shadowing the datapath latency ----
  logic [LAT-1:0] vld_p1;
  req_id_t        id_p1 [LAT];
  logic           tag_vld;
  req_id_t        tag_id;

  // Tag valids shift one stage per cycle; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= '0;
    end else begin
      vld_p1[0] <= vld_p0;
      for (int i = 1; i < LAT; i++) begin
        vld_p1[i] <= vld_p1[i-1];
      end
    end
  end

  // Requester ids ride alongside the valids; meaningless when valid is low
  always_ff @(posedge clk) begin
    id_p1[0] <= id_p0;
    for (int i = 1; i < LAT; i++) begin
      id_p1[i] <= id_p1[i-1];
    end
  end

  // The tag leaving the last stage lines up with dp_res for that issue
  assign tag_vld = vld_p1[LAT-1];
  assign tag_id  = id_p1[LAT-1];

  // ---- stage p2: response registers ----
  logic             rsp0_vld_p2;
  logic             rsp1_vld_p2;
  logic [WIDTH-1:0] rsp0_data_p2;
  logic [WIDTH-1:0] rsp1_data_p2;
  logic             rsp0_ovf_p2;
  logic             rsp1_ovf_p2;

  // Route the datapath result to its owner as a one-cycle pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_vld_p2  <= 1'b0;
      rsp1_vld_p2  <= 1'b0;
      rsp0_data_p2 <= '0;
      rsp1_data_p2 <= '0;
      rsp0_ovf_p2  <= 1'b0;
      rsp1_ovf_p2  <= 1'b0;
    end else begin
      rsp0_vld_p2 <= tag_vld & (tag_id == REQ_ID0);
      rsp1_vld_p2 <= tag_vld & (tag_id == REQ_ID1);
      if (tag_vld && (tag_id == REQ_ID0)) begin
        rsp0_data_p2 <= dp_res;
        rsp0_ovf_p2  <= exp_sat(dp_res);
      end
      if (tag_vld && (tag_id == REQ_ID1)) begin
        rsp1_data_p2 <= dp_res;
        rsp1_ovf_p2  <= exp_sat(dp_res);
      end
    end
  end

  assign rsp0_valid = rsp0_vld_p2;
  assign rsp1_valid = rsp1_vld_p2;
  assign rsp0_data  = rsp0_data_p2;
  assign rsp1_data  = rsp1_data_p2;
  assign rsp0_ovf   = rsp0_ovf_p2;
  assign rsp1_ovf   = rsp1_ovf_p2;

  // Busy only looks at registered state, never at the request inputs
  assign busy = vld_p0 | (|vld_p1);

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Scoreboard bench for fp_addsub_arbiter with a LAT-cycle datapath model.
module tb_fp_addsub_arbiter;

  localparam int W   = 32;
  localparam int LAT = 3;

  // Directed vectors: operands, op and hand-computed single-precision result
  localparam logic [31:0] VA [8] = '{32'h3F800000, 32'h40400000, 32'h40A00000, 32'h41200000,
                                     32'h3F000000, 32'h7F000000, 32'h40800000, 32'hC0000000};
  localparam logic [31:0] VB [8] = '{32'h40000000, 32'h3F800000, 32'h40400000, 32'h40000000,
                                     32'h3F000000, 32'h7F000000, 32'h40800000, 32'h3F800000};
  localparam logic        VOP [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [31:0] VR [8] = '{32'h40400000, 32'h40000000, 32'h41000000, 32'h41000000,
                                     32'h3F800000, 32'h7F800000, 32'h00000000, 32'hBF800000};
  localparam logic        VOVF [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_op, req1_op;
  logic         dp_valid;
  logic [W-1:0] dp_a, dp_b;
  logic         dp_op;
  logic [W-1:0] dp_res;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic         rsp0_ovf, rsp1_ovf;
  logic         busy;

  fp_addsub_arbiter #(.WIDTH(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op), .dp_res(dp_res),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ovf(rsp0_ovf),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ovf(rsp1_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: looks the operation up in the vector table
  function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    for (int k = 0; k < 8; k++) begin
      if (VA[k] == a && VB[k] == b && VOP[k] == op) return VR[k];
    end
    return 32'hDEADBEEF;
  endfunction

  logic [31:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= dp_valid ? dp_model(dp_a, dp_b, dp_op) : 32'h0;
    for (int k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
  end
  assign dp_res = dp_pipe[LAT-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t exp_q [$];

  // Monitor: every response pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (rsp0_valid || rsp1_valid) begin
      chk("rsp_onehot", {31'b0, rsp0_valid & rsp1_valid}, 32'h0);
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {31'b0, rsp1_valid}, 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", {31'b0, rsp1_valid}, {31'b0, e.id});
        chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, e.data);
        chk("rsp_ovf", {31'b0, rsp1_valid ? rsp1_ovf : rsp0_ovf}, {31'b0, e.ovf});
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one cycle of requests, check readies, record expected responses
  task automatic step(input logic v0, input int i0, input logic v1, input int i1,
                      input logic e, input logic x0, input logic x1);
    exp_t ex;
    req0_valid = v0; req0_a = VA[i0]; req0_b = VB[i0]; req0_op = VOP[i0];
    req1_valid = v1; req1_a = VA[i1]; req1_b = VB[i1]; req1_op = VOP[i1];
    en = e;
    #1;
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, x0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, x1});
    if (x0) begin
      ex.id = 1'b0; ex.data = VR[i0]; ex.ovf = VOVF[i0]; ex.cyc = cyc + LAT + 2;
      exp_q.push_back(ex);
    end
    if (x1) begin
      ex.id = 1'b1; ex.data = VR[i1]; ex.ovf = VOVF[i1]; ex.cyc = cyc + LAT + 2;
      exp_q.push_back(ex);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_dp_valid", {31'b0, dp_valid}, 32'h0);
    chk("rst_dp_a", dp_a, 32'h0);
    chk("rst_dp_b", dp_b, 32'h0);
    chk("rst_dp_op", {31'b0, dp_op}, 32'h0);
    chk("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
    chk("rst_rsp0_data", rsp0_data, 32'h0);
    chk("rst_rsp1_data", rsp1_data, 32'h0);
    chk("rst_rsp_ovf", {30'b0, rsp1_ovf, rsp0_ovf}, 32'h0);
    rst_n = 1'b1;

    // Lone req0: 1.0 + 2.0, issue visible the following cycle
    step(1'b1, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("dp_valid_issue", {31'b0, dp_valid}, 32'h1);
    chk("dp_a_issue", dp_a, 32'h3F800000);
    chk("dp_b_issue", dp_b, 32'h40000000);
    chk("dp_op_issue", {31'b0, dp_op}, 32'h0);
    chk("busy_issue", {31'b0, busy}, 32'h1);
    idle(1);
    chk("dp_valid_gap", {31'b0, dp_valid}, 32'h0);
    chk("dp_a_hold", dp_a, 32'h3F800000);

    // Lone req1 (3.0 - 1.0), then req0 back-to-back with no bubbles
    step(1'b0, 0, 1'b1, 1, 1'b1, 1'b0, 1'b1);
    chk("dp_op_sub", {31'b0, dp_op}, 32'h1);
    step(1'b1, 4, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 7, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 6, 1'b1, 1'b0, 1'b1);

    // Both valid for four cycles: grants alternate 0,1,0,1
    step(1'b1, 2, 1'b1, 3, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4, 1'b1, 3, 1'b1, 1'b0, 1'b1);
    step(1'b1, 4, 1'b1, 6, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1, 1'b1, 6, 1'b1, 1'b0, 1'b1);

    // Overflowing add accepted, then en drops with both requesters waiting
    step(1'b1, 5, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 0, 1'b1, 7, 1'b0, 1'b0, 1'b0);
    chk("busy_en_low", {31'b0, busy}, 32'h1);
    step(1'b1, 0, 1'b1, 7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b1, 7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b1, 7, 1'b1, 1'b0, 1'b1);
    idle(8);
    chk("busy_drained", {31'b0, busy}, 32'h0);

    // Two ops in flight, priority left at req1, then a one-cycle reset
    step(1'b0, 0, 1'b1, 1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    exp_q.delete();
    idle(1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("busy_after_rst", {31'b0, busy}, 32'h0);
    chk("dp_valid_after_rst", {31'b0, dp_valid}, 32'h0);
    chk("rsp_after_rst", {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
    step(1'b1, 3, 1'b1, 4, 1'b1, 1'b1, 1'b0);
    idle(10);
    chk("rsp_outstanding", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_addsub_arbiter.md
FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width (IEEE 754 single).
REQ-002 Parameter LAT, default 3, fixed latency in cycles of the shared add/sub + normalize_rounder datapath, range 1..8.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 en  in  1  grant enable; low blocks new grants only.
REQ-006 req0_valid / req1_valid  in  1  requester N has an operation.
REQ-007 req0_ready / req1_ready  out  1  requester N's operation is accepted this cycle.
REQ-008 req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
REQ-009 req0_op / req1_op  in  1  0 = add, 1 = subtract.
REQ-010 dp_valid  out  1  issue strobe to the datapath.
REQ-011 dp_a, dp_b  out  WIDTH  issued operands.
REQ-012 dp_op  out  1  issued op.
REQ-013 dp_res  in  WIDTH  datapath result, valid exactly LAT cycles after its dp_valid.
REQ-014 rsp0_valid / rsp1_valid  out  1  one-cycle result pulse to requester N, no backpressure.
REQ-015 rsp0_data / rsp1_data  out  WIDTH  result.
REQ-016 rsp0_ovf / rsp1_ovf  out  1  result exponent field equals 8'hFF.
REQ-017 busy  out  1  any operation is in the issue register or the tag pipeline.

Function
REQ-018 Transfer on requester N SHALL occur when reqN_valid & reqN_ready; at most one ready is high per cycle.
REQ-019 readyN SHALL be combinational: en & reqN_valid & (N holds priority | other requester not valid).
REQ-020 Round-robin priority SHALL pass to the other requester after each grant and stay unchanged in cycles without a grant.
REQ-021 A lone valid requester SHALL be granted every cycle with no bubbles; with both valid, grants SHALL alternate 0,1,0,1.
REQ-022 An operation accepted in cycle T SHALL drive dp_valid/dp_a/dp_b/dp_op from the issue register in cycle T+1; dp_valid=0 otherwise, and dp_a/dp_b/dp_op hold their last values.
REQ-023 A LAT-deep tag shift register SHALL carry {valid, requester id} alongside each issue.
REQ-024 When the tag exits in cycle T+1+LAT, dp_res SHALL be registered to rspN_data with rspN_valid=1 in cycle T+2+LAT; rspN_ovf = (dp_res[30:23]==8'hFF).
REQ-025 Responses SHALL return in issue order; only the addressed rspN_valid pulses; both SHALL never be high together.
REQ-026 en low SHALL stop grants only; in-flight operations complete and respond normally.
REQ-027 Throughput SHALL be one operation per cycle sustained; no internal stall path exists.
REQ-028 busy SHALL be the OR of the issue-register valid and all tag valids, registered-state-derived with no combinational input path.

Reset
REQ-029 rst_n low at a clock edge SHALL clear issue valid, all tags, rsp*_valid, rsp*_ovf, and busy, and set priority to requester 0.
REQ-030 rsp*_data and dp_a/dp_b/dp_op SHALL reset to 0.
REQ-031 Operations in flight at reset SHALL be dropped: no response is produced, and dp_res arriving after reset is ignored.

Structure
REQ-032 Shared package fp_addsub_pkg SHALL hold FP_WIDTH=32, EXP_MSB=30, EXP_LSB=23, op typedef (OP_ADD=0, OP_SUB=1), and req_id typedef (1 bit).
REQ-033 One sub-module rr_arbiter2 SHALL implement the 2-way round-robin grant and priority register; the datapath SHALL be instantiated outside this block.

Verification (LAT=3, datapath model returns a+b or a-b)
REQ-034 req0 alone: a=3F800000, b=40000000, add, accepted in cycle 0 -> dp_valid in cycle 1; rsp0_valid in cycle 5 with 40400000; rsp1_valid stays 0.
REQ-035 Both valid for 4 cycles -> grants 0,1,0,1; responses in cycles 5..8 alternate rsp0/rsp1 in the same order.
REQ-036 en=0 while both are valid -> both ready=0; an op accepted before en fell still responds after LAT+2 cycles.
REQ-037 Result 7F800000 (overflow model) -> rspN_ovf=1 with the valid pulse.
REQ-038 rst_n low in cycle 3 with 2 ops in flight -> no rsp pulse afterwards; busy=0; next grant goes to req0 when both are valid.
